// File: rtl/writeback_pipe.sv
// writeback_pipe: result-aging and write-back stage between the even/odd
// execution units and the register file. Each pipe's 143-bit result packet
// ages through a DEPTH-stage shift chain. Same-RT write pairs are resolved
// when entering the final stage, so the younger write wins. Branch flush
// kills the write enable of the two youngest packets per pipe.
// Optional build macro WB_COLLISION_CNT_EN adds a saturating collision_count.
module writeback_pipe #(
    parameter int DEPTH = 7
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [0:142] ep_pkt_in,
    input  logic [0:142] op_pkt_in,
    input  logic         ep_older,
    input  logic         flush,
    output logic [0:142] wrt_back_arr_ep,
    output logic [0:142] wrt_back_arr_op,
    output logic         collision
`ifdef WB_COLLISION_CNT_EN
    ,
    output logic [0:15]  collision_count
`endif
);

    localparam int WEN = 131;

    // Only the write enable is ever modified; every other field passes through.
    function automatic logic [0:142] clear_wen(input logic [0:142] pkt);
        logic [0:142] res;
        res      = pkt;
        res[WEN] = 1'b0;
        return res;
    endfunction

    // Both packets write, and to the same RT (RT 0 is an ordinary register).
    function automatic logic same_rt_write(input logic [0:142] a, input logic [0:142] b);
        return a[WEN] && b[WEN] && (a[132:138] == b[132:138]);
    endfunction

    // Stages S1..S_(DEPTH-1); S_DEPTH is the output register pair itself.
    logic [0:142] ep_chain_p    [1:DEPTH-1];
    logic [0:142] op_chain_p    [1:DEPTH-1];
    logic         older_chain_p [1:DEPTH-1];

    // Packet leaving stage k, after flush masking of the S1 -> S2 move.
    logic [0:142] ep_move [1:DEPTH-1];
    logic [0:142] op_move [1:DEPTH-1];

    logic [0:142] ep_final;
    logic [0:142] op_final;
    logic         hit;

    // Flush kills the packets moving out of S1 in the same cycle.
    always_comb begin
        for (int k = 1; k < DEPTH; k++) begin
            ep_move[k] = ep_chain_p[k];
            op_move[k] = op_chain_p[k];
        end
        if (flush) begin
            ep_move[1] = clear_wen(ep_chain_p[1]);
            op_move[1] = clear_wen(op_chain_p[1]);
        end
    end

    // Resolve same-RT pairs entering S_DEPTH: the older write is dropped.
    always_comb begin
        hit      = same_rt_write(ep_move[DEPTH-1], op_move[DEPTH-1]);
        ep_final = ep_move[DEPTH-1];
        op_final = op_move[DEPTH-1];
        if (hit) begin
            if (older_chain_p[DEPTH-1]) begin
                ep_final = clear_wen(ep_move[DEPTH-1]);
            end else begin
                op_final = clear_wen(op_move[DEPTH-1]);
            end
        end
    end

    // Shift chain and output registers; reset discards everything in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k < DEPTH; k++) begin
                ep_chain_p[k]    <= '0;
                op_chain_p[k]    <= '0;
                older_chain_p[k] <= 1'b0;
            end
            wrt_back_arr_ep <= '0;
            wrt_back_arr_op <= '0;
            collision       <= 1'b0;
        end else begin
            ep_chain_p[1]    <= flush ? clear_wen(ep_pkt_in) : ep_pkt_in;
            op_chain_p[1]    <= flush ? clear_wen(op_pkt_in) : op_pkt_in;
            older_chain_p[1] <= ep_older;
            for (int k = 2; k < DEPTH; k++) begin
                ep_chain_p[k]    <= ep_move[k-1];
                op_chain_p[k]    <= op_move[k-1];
                older_chain_p[k] <= older_chain_p[k-1];
            end
            wrt_back_arr_ep <= ep_final;
            wrt_back_arr_op <= op_final;
            collision       <= hit;
        end
    end

`ifdef WB_COLLISION_CNT_EN
    // Count cycles with a resolved collision on the outputs, holding at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            collision_count <= '0;
        end else if (collision && (collision_count != 16'hFFFF)) begin
            collision_count <= collision_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_pipe.sv
// Testbench for writeback_pipe (DEPTH = 7). A history of presented inputs is
// kept per cycle; the expected output pair for cycle t is derived from the
// inputs of cycle t-DEPTH and the flush values of cycles t-DEPTH and t-DEPTH+1.
module tb_writeback_pipe;
    localparam int DEPTH = 7;
    localparam int HN    = 64;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [0:142] ep_pkt_in = '0;
    logic [0:142] op_pkt_in = '0;
    logic         ep_older = 1'b0;
    logic         flush = 1'b0;
    logic [0:142] wrt_back_arr_ep;
    logic [0:142] wrt_back_arr_op;
    logic         collision;
`ifdef WB_COLLISION_CNT_EN
    logic [0:15]  collision_count;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [0:142] h_ep  [HN];
    logic [0:142] h_op  [HN];
    logic         h_old [HN];
    logic         h_fl  [HN];
    logic [0:142] exp_ep;
    logic [0:142] exp_op;
    logic         exp_col;

    writeback_pipe #(.DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .ep_pkt_in       (ep_pkt_in),
        .op_pkt_in       (op_pkt_in),
        .ep_older        (ep_older),
        .flush           (flush),
        .wrt_back_arr_ep (wrt_back_arr_ep),
        .wrt_back_arr_op (wrt_back_arr_op),
        .collision       (collision)
`ifdef WB_COLLISION_CNT_EN
        ,
        .collision_count (collision_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [0:142] mk(input logic [2:0] unit, input logic [127:0] res,
                                        input logic wen, input logic [6:0] rt, input logic [3:0] lat);
        return {unit, res, wen, rt, lat};
    endfunction

    function automatic logic [0:142] rnd_pkt(input int rtmax);
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return mk(3'($urandom), r, 1'($urandom), 7'($urandom_range(rtmax)), 4'($urandom));
    endfunction

    // Reference: what the register file must see in the current cycle.
    function automatic void model();
        int n;
        logic [0:142] e;
        logic [0:142] o;
        n = cyc - DEPTH;
        exp_ep  = '0;
        exp_op  = '0;
        exp_col = 1'b0;
        if (n >= 0) begin
            e = h_ep[n % HN];
            o = h_op[n % HN];
            if (h_fl[n % HN] || h_fl[(n + 1) % HN]) begin
                e[131] = 1'b0;
                o[131] = 1'b0;
            end
            if (e[131] && o[131] && (e[132:138] == o[132:138])) begin
                exp_col = 1'b1;
                if (h_old[n % HN]) e[131] = 1'b0;
                else               o[131] = 1'b0;
            end
            exp_ep = e;
            exp_op = o;
        end
    endfunction

    // One cycle: compute expectation for the outputs now visible, then drive inputs.
    task automatic tick(input logic [0:142] e, input logic [0:142] o, input logic old, input logic fl);
        @(negedge clock);
        model();
        ep_pkt_in = e;
        op_pkt_in = o;
        ep_older  = old;
        flush     = fl;
        h_ep[cyc % HN]  = e;
        h_op[cyc % HN]  = o;
        h_old[cyc % HN] = old;
        h_fl[cyc % HN]  = fl;
        cyc++;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        ep_pkt_in = '0;
        op_pkt_in = '0;
        ep_older  = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({wrt_back_arr_ep, wrt_back_arr_op, collision} !== '0) begin
            failures++;
            $display("FAIL reset_state got ep=%h op=%h col=%b required all zero", wrt_back_arr_ep, wrt_back_arr_op, collision);
        end
        repeat (DEPTH + 2) begin
            tick('0, '0, 1'b0, 1'b0);
            checks++;
            if ({wrt_back_arr_ep, wrt_back_arr_op, collision} !== {exp_ep, exp_op, exp_col}) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%h/%h/%b required=%h/%h/%b", cyc - 1,
                         wrt_back_arr_ep, wrt_back_arr_op, collision, exp_ep, exp_op, exp_col);
            end
        end
    endtask

    task automatic test_single();
        logic [0:142] pa;
        pa = mk(3'd1, {16{8'hA5}}, 1'b1, 7'd5, 4'd6);
        do_reset();
        for (int i = 0; i < DEPTH + 5; i++) begin
            tick(i == 0 ? pa : '0, '0, 1'b0, 1'b0);
            checks++;
            if ({wrt_back_arr_ep, wrt_back_arr_op, collision} !== {exp_ep, exp_op, exp_col}) begin
                failures++;
                $display("FAIL single cyc=%0d got=%h/%h/%b required=%h/%h/%b", cyc - 1,
                         wrt_back_arr_ep, wrt_back_arr_op, collision, exp_ep, exp_op, exp_col);
            end
            checks++;
            if (wrt_back_arr_op[131] !== 1'b0) begin
                failures++;
                $display("FAIL single_op_wen cyc=%0d got=%b required=0", cyc - 1, wrt_back_arr_op[131]);
            end
            if (cyc - 1 == 7) begin
                checks++;
                if (wrt_back_arr_ep !== pa) begin
                    failures++;
                    $display("FAIL single_at7 got=%h required=%h", wrt_back_arr_ep, pa);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [0:142] e;
        logic [0:142] o;
        do_reset();
        for (int i = 0; i < 10 + DEPTH + 2; i++) begin
            e = '0;
            o = '0;
            if (i < 10) begin
                e = mk(3'd2, 128'(i + 1) * 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F, 1'b1, 7'(i + 1), 4'd2);
                o = mk(3'd5, ~(128'(i + 1) * 128'h1111), 1'b1, 7'(i + 65), 4'd3);
            end
            tick(e, o, 1'($urandom), 1'b0);
            checks++;
            if ({wrt_back_arr_ep, wrt_back_arr_op, collision} !== {exp_ep, exp_op, exp_col}) begin
                failures++;
                $display("FAIL b2b cyc=%0d got=%h/%h/%b required=%h/%h/%b", cyc - 1,
                         wrt_back_arr_ep, wrt_back_arr_op, collision, exp_ep, exp_op, exp_col);
            end
            if ((cyc - 1 >= 7) && (cyc - 1 <= 16)) begin
                checks++;
                if ({wrt_back_arr_ep[131], wrt_back_arr_ep[132:138]} !== {1'b1, 7'(cyc - 7)}) begin
                    failures++;
                    $display("FAIL b2b_seq cyc=%0d got wen=%b rt=%0d required wen=1 rt=%0d", cyc - 1,
                             wrt_back_arr_ep[131], wrt_back_arr_ep[132:138], cyc - 7);
                end
            end
        end
    endtask

    task automatic test_collision();
        logic [0:142] e;
        logic [0:142] o;
        e = mk(3'd3, {4{32'hDEAD_BEEF}}, 1'b1, 7'd20, 4'd4);
        o = mk(3'd4, {4{32'h1234_5678}}, 1'b1, 7'd20, 4'd5);
        do_reset();
        for (int i = 0; i < DEPTH + 4; i++) begin
            tick(i == 0 || i == 1 ? e : '0, i == 0 || i == 1 ? o : '0, i == 0, 1'b0);
            checks++;
            if ({wrt_back_arr_ep, wrt_back_arr_op, collision} !== {exp_ep, exp_op, exp_col}) begin
                failures++;
                $display("FAIL collision cyc=%0d got=%h/%h/%b required=%h/%h/%b", cyc - 1,
                         wrt_back_arr_ep, wrt_back_arr_op, collision, exp_ep, exp_op, exp_col);
            end
            if (cyc - 1 == 7 || cyc - 1 == 8) begin
                checks++;
                if ({wrt_back_arr_ep[131], wrt_back_arr_op[131], collision} !==
                    (cyc - 1 == 7 ? 3'b011 : 3'b101)) begin
                    failures++;
                    $display("FAIL collision_wen cyc=%0d got ep=%b op=%b col=%b", cyc - 1,
                             wrt_back_arr_ep[131], wrt_back_arr_op[131], collision);
                end
                checks++;
                if (wrt_back_arr_ep[0:130] !== e[0:130] || wrt_back_arr_op[132:142] !== o[132:142]) begin
                    failures++;
                    $display("FAIL collision_data cyc=%0d got ep=%h op=%h", cyc - 1, wrt_back_arr_ep, wrt_back_arr_op);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [0:142] p;
        do_reset();
        for (int i = 0; i < DEPTH + 5; i++) begin
            p = (i < 3) ? mk(3'(i), 128'hC0FFEE + 128'(i), 1'b1, 7'(30 + i), 4'd1) : '0;
            tick(p, (i < 3) ? mk(3'd7, 128'(i), 1'b1, 7'(40 + i), 4'd1) : '0, 1'b1, i == 2);
            checks++;
            if ({wrt_back_arr_ep, wrt_back_arr_op, collision} !== {exp_ep, exp_op, exp_col}) begin
                failures++;
                $display("FAIL flush cyc=%0d got=%h/%h/%b required=%h/%h/%b", cyc - 1,
                         wrt_back_arr_ep, wrt_back_arr_op, collision, exp_ep, exp_op, exp_col);
            end
            if (cyc - 1 >= 7 && cyc - 1 <= 9) begin
                checks++;
                if (wrt_back_arr_ep[131] !== (cyc - 1 == 7) || wrt_back_arr_ep[132:138] !== 7'(30 + cyc - 8)) begin
                    failures++;
                    $display("FAIL flush_wen cyc=%0d got wen=%b rt=%0d", cyc - 1,
                             wrt_back_arr_ep[131], wrt_back_arr_ep[132:138]);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (400) begin
            tick(rnd_pkt(3), rnd_pkt(3), 1'($urandom), $urandom_range(7) == 0);
            checks++;
            if ({wrt_back_arr_ep, wrt_back_arr_op, collision} !== {exp_ep, exp_op, exp_col}) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h/%h/%b required=%h/%h/%b", cyc - 1,
                         wrt_back_arr_ep, wrt_back_arr_op, collision, exp_ep, exp_op, exp_col);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [0:142] e;
        do_reset();
        for (int i = 0; i < DEPTH + 3; i++) begin
            e = rnd_pkt(100);
            e[131] = 1'b1;
            tick(e, e, 1'b1, 1'b0);
        end
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({wrt_back_arr_ep, wrt_back_arr_op, collision} !== '0) begin
            failures++;
            $display("FAIL midflight_async got ep=%h op=%h col=%b required all zero", wrt_back_arr_ep, wrt_back_arr_op, collision);
        end
        ep_pkt_in = '0;
        op_pkt_in = '0;
        @(posedge clock);
        #1 reset = 1'b1;
        cyc = 0;
        repeat (DEPTH + 4) begin
            tick('0, '0, 1'b0, 1'b0);
            checks++;
            if ({wrt_back_arr_ep[131], wrt_back_arr_op[131], collision} !== {exp_ep[131], exp_op[131], exp_col}) begin
                failures++;
                $display("FAIL midflight_idle cyc=%0d got ep_wen=%b op_wen=%b col=%b required all 0", cyc - 1,
                         wrt_back_arr_ep[131], wrt_back_arr_op[131], collision);
            end
        end
    endtask

`ifdef WB_COLLISION_CNT_EN
    task automatic test_collision_count();
        logic [0:142] c;
        c = mk(3'd0, 128'h55, 1'b1, 7'd9, 4'd0);
        do_reset();
        for (int i = 0; i < DEPTH + 6; i++) tick(i < 3 ? c : '0, i < 3 ? c : '0, 1'b1, 1'b0);
        checks++;
        if (collision_count !== 16'd3) begin
            failures++;
            $display("FAIL count_three got=%0d required=3", collision_count);
        end
        do_reset();
        for (int i = 0; i < 65540 + DEPTH + 3; i++) tick(i < 65540 ? c : '0, i < 65540 ? c : '0, 1'b0, 1'b0);
        checks++;
        if (collision_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL count_saturate got=%h required=ffff", collision_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_collision();
        test_flush();
        test_random();
        test_reset_midflight();
`ifdef WB_COLLISION_CNT_EN
        test_collision_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
